// File: rtl/stat_bcd_ctrl_pkg.sv
// Shared definitions for the status-number BCD path: digit/number types,
// display limits, controller states and the double-dabble digit adjust.
package stat_bcd_ctrl_pkg;

   localparam int unsigned NUMBER_LEN = 6;
   localparam int unsigned BCD_MAX    = 999999;
   localparam int unsigned NUM_COUNT  = 3;

   typedef logic [3:0] bcd_digit_t;
   typedef bcd_digit_t [NUMBER_LEN-1:0] bcd_num_t;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CONV       = 2'd1,
      ST_WAIT_FRAME = 2'd2,
      ST_COMMIT     = 2'd3
   } state_e;

   // Double-dabble pre-shift correction for one digit.
   function automatic bcd_digit_t dd_adjust(input bcd_digit_t d);
      return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/stat_bcd_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per cycle.
//   clk_i, rst_n_i : clock, async active-low reset
//   start_i        : load bin_i and perform the first iteration on this edge
//   bin_i          : binary value (must already be <= 10^DIGITS-1)
//   done_o         : one-cycle flag, bcd_o holds the finished result
//   bcd_o          : packed BCD digits, digit 0 in bits [3:0]
// Latency: start at edge S, done_o high during the cycle after edge S+BIN_WIDTH-1.
module bin2bcd_seq
   import stat_bcd_ctrl_pkg::*;
#(
   parameter int unsigned BIN_WIDTH = 20,
   parameter int unsigned DIGITS    = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [BIN_WIDTH-1:0]  bin_i,
   output logic                  done_o,
   output logic [DIGITS*4-1:0]   bcd_o
);

   localparam int unsigned BCD_W = DIGITS * 4;
   localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   // One iteration: correct every digit, then shift BCD:binary left as a unit.
   function automatic logic [BCD_W+BIN_WIDTH-1:0] dd_step(input logic [BCD_W-1:0]     bcd,
                                                           input logic [BIN_WIDTH-1:0] bin);
      logic [BCD_W-1:0] adj;
      for (int i = 0; i < int'(DIGITS); i++) begin
         adj[i*4 +: 4] = dd_adjust(bcd[i*4 +: 4]);
      end
      return {adj, bin} << 1;
   endfunction

   // Iteration control; a new start always wins over a running conversion.
   always_comb begin
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      if (start_i) begin
         {bcd_d, bin_d} = dd_step('0, bin_i);
         cnt_d          = CNT_W'(1);
         active_d       = 1'b1;
      end else if (active_q) begin
         {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
         cnt_d          = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/stat_bcd_ctrl.sv
// Converts score/lines/level to BCD with one shared engine and commits all
// three atomically (optionally at a frame boundary) for the status renderer.
//   clk_i, rst_n_i        : clock, async active-low reset
//   score_i/lines_i/level_i : binary counters
//   update_stb_i          : counters changed, reconvert
//   frame_start_i         : start of vertical blank
//   score/lines/level_bcd_o : committed digits, digit 0 = LSD
//   blank_o               : leading-zero mask, number n at [n*DIGITS +: DIGITS]
//   sat_o                 : input was clamped to 999999 (0=score,1=lines,2=level)
//   busy_o                : controller not idle
module stat_bcd_ctrl
   import stat_bcd_ctrl_pkg::*;
#(
   parameter int unsigned BIN_WIDTH     = 20,
   parameter int unsigned DIGITS        = 6,
   parameter int unsigned SYNC_TO_FRAME = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [BIN_WIDTH-1:0]          score_i,
   input  logic [BIN_WIDTH-1:0]          lines_i,
   input  logic [BIN_WIDTH-1:0]          level_i,
   input  logic                          update_stb_i,
   input  logic                          frame_start_i,
   output logic [DIGITS*4-1:0]           score_bcd_o,
   output logic [DIGITS*4-1:0]           lines_bcd_o,
   output logic [DIGITS*4-1:0]           level_bcd_o,
   output logic [NUM_COUNT*DIGITS-1:0]   blank_o,
   output logic [NUM_COUNT-1:0]          sat_o,
   output logic                          busy_o
);

   localparam int unsigned BCD_W = DIGITS * 4;
   localparam logic [NUM_COUNT*DIGITS-1:0] BLANK_RST =
      {NUM_COUNT{{(DIGITS-1){1'b1}}, 1'b0}};

   state_e                       state_q, state_d;
   logic [1:0]                   idx_q, idx_d;
   logic                         pending_q, pending_d;
   logic [BIN_WIDTH-1:0]         snap_lines_q, snap_lines_d;
   logic [BIN_WIDTH-1:0]         snap_level_q, snap_level_d;
   logic [NUM_COUNT-1:0]         sat_sh_q, sat_sh_d;
   logic [BCD_W-1:0]             sh_score_q, sh_score_d;
   logic [BCD_W-1:0]             sh_lines_q, sh_lines_d;
   logic [BCD_W-1:0]             sh_level_q, sh_level_d;
   logic [BCD_W-1:0]             score_bcd_q, score_bcd_d;
   logic [BCD_W-1:0]             lines_bcd_q, lines_bcd_d;
   logic [BCD_W-1:0]             level_bcd_q, level_bcd_d;
   logic [NUM_COUNT*DIGITS-1:0]  blank_q, blank_d;
   logic [NUM_COUNT-1:0]         sat_q, sat_d;
   logic                         busy_q, busy_d;

   logic                         eng_start_c;
   logic [BIN_WIDTH-1:0]         eng_bin_c;
   logic                         eng_done;
   logic [BCD_W-1:0]             eng_bcd;

   function automatic logic over_max(input logic [BIN_WIDTH-1:0] v);
      return v > BIN_WIDTH'(BCD_MAX);
   endfunction

   function automatic logic [BIN_WIDTH-1:0] clamp(input logic [BIN_WIDTH-1:0] v);
      return over_max(v) ? BIN_WIDTH'(BCD_MAX) : v;
   endfunction

   // Bit k set while digits DIGITS-1..k are all zero; digit 0 always shown.
   function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] num);
      logic [DIGITS-1:0] m;
      logic              zero_run;
      m        = '0;
      zero_run = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         zero_run = zero_run & (num[k*4 +: 4] == 4'd0);
         m[k]     = zero_run;
      end
      return m;
   endfunction

   bin2bcd_seq #(
      .BIN_WIDTH (BIN_WIDTH),
      .DIGITS    (DIGITS)
   ) u_engine (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .start_i (eng_start_c),
      .bin_i   (eng_bin_c),
      .done_o  (eng_done),
      .bcd_o   (eng_bcd)
   );

   // Controller next-state, engine sequencing and commit.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pending_d    = pending_q;
      snap_lines_d = snap_lines_q;
      snap_level_d = snap_level_q;
      sat_sh_d     = sat_sh_q;
      sh_score_d   = sh_score_q;
      sh_lines_d   = sh_lines_q;
      sh_level_d   = sh_level_q;
      score_bcd_d  = score_bcd_q;
      lines_bcd_d  = lines_bcd_q;
      level_bcd_d  = level_bcd_q;
      blank_d      = blank_q;
      sat_d        = sat_q;
      eng_start_c  = 1'b0;
      eng_bin_c    = clamp(score_i);

      // Strobes while busy (COMMIT included) collapse into one pending request.
      if (update_stb_i && (state_q != ST_IDLE)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (update_stb_i || pending_q) begin
               pending_d    = 1'b0;
               eng_start_c  = 1'b1;
               snap_lines_d = clamp(lines_i);
               snap_level_d = clamp(level_i);
               sat_sh_d     = {over_max(level_i), over_max(lines_i), over_max(score_i)};
               idx_d        = 2'd0;
               state_d      = ST_CONV;
            end
         end
         ST_CONV: begin
            if (eng_done) begin
               unique case (idx_q)
                  2'd0: begin
                     sh_score_d  = eng_bcd;
                     eng_start_c = 1'b1;
                     eng_bin_c   = snap_lines_q;
                     idx_d       = 2'd1;
                  end
                  2'd1: begin
                     sh_lines_d  = eng_bcd;
                     eng_start_c = 1'b1;
                     eng_bin_c   = snap_level_q;
                     idx_d       = 2'd2;
                  end
                  default: begin
                     sh_level_d = eng_bcd;
                     state_d    = (SYNC_TO_FRAME != 0) ? ST_WAIT_FRAME : ST_COMMIT;
                  end
               endcase
            end
         end
         ST_WAIT_FRAME: begin
            if (frame_start_i) begin
               state_d = ST_COMMIT;
            end
         end
         default: begin
            score_bcd_d = sh_score_q;
            lines_bcd_d = sh_lines_q;
            level_bcd_d = sh_level_q;
            sat_d       = sat_sh_q;
            blank_d     = {blank_mask(sh_level_q), blank_mask(sh_lines_q), blank_mask(sh_score_q)};
            state_d     = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         pending_q    <= 1'b0;
         snap_lines_q <= '0;
         snap_level_q <= '0;
         sat_sh_q     <= '0;
         sh_score_q   <= '0;
         sh_lines_q   <= '0;
         sh_level_q   <= '0;
         score_bcd_q  <= '0;
         lines_bcd_q  <= '0;
         level_bcd_q  <= '0;
         blank_q      <= BLANK_RST;
         sat_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         snap_lines_q <= snap_lines_d;
         snap_level_q <= snap_level_d;
         sat_sh_q     <= sat_sh_d;
         sh_score_q   <= sh_score_d;
         sh_lines_q   <= sh_lines_d;
         sh_level_q   <= sh_level_d;
         score_bcd_q  <= score_bcd_d;
         lines_bcd_q  <= lines_bcd_d;
         level_bcd_q  <= level_bcd_d;
         blank_q      <= blank_d;
         sat_q        <= sat_d;
         busy_q       <= busy_d;
      end
   end

   assign score_bcd_o = score_bcd_q;
   assign lines_bcd_o = lines_bcd_q;
   assign level_bcd_o = level_bcd_q;
   assign blank_o     = blank_q;
   assign sat_o       = sat_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_stat_bcd_ctrl.sv
// Directed + randomized bench for stat_bcd_ctrl: one instance commits
// immediately, one waits for a frame pulse. Expected values come from
// decimal arithmetic on the clamped inputs.
module tb_stat_bcd_ctrl;

   logic        clk;
   logic        rst_n;
   logic [19:0] score, lines, level;
   logic        upd0, upd1, frame;

   logic [23:0] d0_score, d0_lines, d0_level, d1_score, d1_lines, d1_level;
   logic [17:0] d0_blank, d1_blank;
   logic [2:0]  d0_sat, d1_sat;
   logic        d0_busy, d1_busy;

   int checks = 0;
   int errors = 0;

   // committed-value model per instance
   int unsigned m0_s, m0_l, m0_v, m1_s, m1_l, m1_v;

   stat_bcd_ctrl #(.BIN_WIDTH(20), .DIGITS(6), .SYNC_TO_FRAME(0)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .score_i(score), .lines_i(lines), .level_i(level),
      .update_stb_i(upd0), .frame_start_i(frame),
      .score_bcd_o(d0_score), .lines_bcd_o(d0_lines), .level_bcd_o(d0_level),
      .blank_o(d0_blank), .sat_o(d0_sat), .busy_o(d0_busy));

   stat_bcd_ctrl #(.BIN_WIDTH(20), .DIGITS(6), .SYNC_TO_FRAME(1)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .score_i(score), .lines_i(lines), .level_i(level),
      .update_stb_i(upd1), .frame_start_i(frame),
      .score_bcd_o(d1_score), .lines_bcd_o(d1_lines), .level_bcd_o(d1_level),
      .blank_o(d1_blank), .sat_o(d1_sat), .busy_o(d1_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned clampv(input int unsigned v);
      return (v > 999999) ? 999999 : v;
   endfunction

   function automatic logic [23:0] exp_bcd(input int unsigned v);
      int unsigned c = clampv(v);
      logic [23:0] r;
      for (int k = 0; k < 6; k++) begin
         r[k*4 +: 4] = 4'(c % 10);
         c = c / 10;
      end
      return r;
   endfunction

   // digit k (k>=1) is a leading zero exactly when the value is below 10^k
   function automatic logic [5:0] exp_blank(input int unsigned v);
      int unsigned c = clampv(v);
      int unsigned p = 1;
      logic [5:0]  m = '0;
      for (int k = 1; k < 6; k++) begin
         p    = p * 10;
         m[k] = (c < p);
      end
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input bit which, input string tag,
                            input int unsigned s, input int unsigned l, input int unsigned v);
      logic [23:0] os, ol, ov;
      logic [17:0] ob;
      logic [2:0]  osat;
      if (which) begin
         os = d1_score; ol = d1_lines; ov = d1_level; ob = d1_blank; osat = d1_sat;
      end else begin
         os = d0_score; ol = d0_lines; ov = d0_level; ob = d0_blank; osat = d0_sat;
      end
      chk({tag, " score"}, 64'(os), 64'(exp_bcd(s)));
      chk({tag, " lines"}, 64'(ol), 64'(exp_bcd(l)));
      chk({tag, " level"}, 64'(ov), 64'(exp_bcd(v)));
      chk({tag, " blank"}, 64'(ob), 64'({exp_blank(v), exp_blank(l), exp_blank(s)}));
      chk({tag, " sat"}, 64'(osat), 64'({v > 999999, l > 999999, s > 999999}));
   endtask

   // drive inputs and strobe instance 0; returns just after edge N
   task automatic start0(input int unsigned s, input int unsigned l, input int unsigned v);
      score = 20'(s); lines = 20'(l); level = 20'(v);
      upd0  = 1'b1;
      tick();
      upd0  = 1'b0;
   endtask

   task automatic start1(input int unsigned s, input int unsigned l, input int unsigned v);
      score = 20'(s); lines = 20'(l); level = 20'(v);
      upd1  = 1'b1;
      tick();
      upd1  = 1'b0;
   endtask

   initial begin
      int unsigned s, l, v;
      int          busy_low;

      rst_n = 1'b0; upd0 = 1'b0; upd1 = 1'b0; frame = 1'b0;
      score = '0; lines = '0; level = '0;
      m0_s = 0; m0_l = 0; m0_v = 0; m1_s = 0; m1_l = 0; m1_v = 0;
      repeat (3) tick();
      check_out(1'b0, "reset d0", 0, 0, 0);
      check_out(1'b1, "reset d1", 0, 0, 0);
      chk("reset busy0", 64'(d0_busy), 64'(0));
      chk("reset busy1", 64'(d1_busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // basic conversion, immediate commit at N+61
      start0(123456, 42, 7);
      chk("t1 busy N", 64'(d0_busy), 64'(1));
      repeat (60) tick();
      check_out(1'b0, "t1 N+60 hold", m0_s, m0_l, m0_v);
      tick();
      m0_s = 123456; m0_l = 42; m0_v = 7;
      check_out(1'b0, "t1 N+61", m0_s, m0_l, m0_v);
      chk("t1 busy after", 64'(d0_busy), 64'(0));
      tick();

      // randomized values, odd rounds in the clamping range
      for (int i = 0; i < 6; i++) begin
         s = (i % 2 == 1) ? $urandom_range(999990, 1048575) : $urandom_range(0, 999999);
         l = (i == 2) ? $urandom_range(0, 1048575) : $urandom_range(0, 9999);
         v = $urandom_range(0, 99);
         start0(s, l, v);
         repeat (60) tick();
         chk("rnd hold score", 64'(d0_score), 64'(exp_bcd(m0_s)));
         tick();
         m0_s = s; m0_l = l; m0_v = v;
         check_out(1'b0, "rnd", s, l, v);
         repeat ($urandom_range(1, 4)) tick();
      end

      // saturation then back to zero
      start0(1048575, 0, 0);
      repeat (61) tick();
      m0_s = 1048575; m0_l = 0; m0_v = 0;
      check_out(1'b0, "sat max", m0_s, m0_l, m0_v);
      tick();
      start0(0, 0, 0);
      repeat (61) tick();
      m0_s = 0;
      check_out(1'b0, "sat zero", m0_s, m0_l, m0_v);
      tick();

      // strobes during conversion collapse into one extra conversion
      start0(777, 1, 2);
      for (int c = 1; c <= 61; c++) begin
         upd0 = (c == 10 || c == 20 || c == 25);
         if (c == 22) score = 20'd5;
         tick();
      end
      upd0 = 1'b0;
      m0_s = 777; m0_l = 1; m0_v = 2;
      check_out(1'b0, "pend first", m0_s, m0_l, m0_v);
      tick();
      chk("pend restart busy", 64'(d0_busy), 64'(1));
      repeat (60) tick();
      chk("pend hold score", 64'(d0_score), 64'(exp_bcd(777)));
      tick();
      m0_s = 5;
      check_out(1'b0, "pend second", m0_s, m0_l, m0_v);
      repeat (20) tick();
      chk("pend no third busy", 64'(d0_busy), 64'(0));
      check_out(1'b0, "pend stable", m0_s, m0_l, m0_v);

      // strobe exactly on the commit edge is kept as pending
      start0(4321, 65, 3);
      for (int c = 1; c <= 61; c++) begin
         upd0 = (c == 61);
         if (c == 61) begin
            score = 20'd98765;
         end
         tick();
      end
      upd0 = 1'b0;
      m0_s = 4321; m0_l = 65; m0_v = 3;
      check_out(1'b0, "cstb first", m0_s, m0_l, m0_v);
      tick();
      chk("cstb restart busy", 64'(d0_busy), 64'(1));
      repeat (61) tick();
      m0_s = 98765;
      check_out(1'b0, "cstb second", m0_s, m0_l, m0_v);
      tick();

      // frame-synchronised commit: early frame ignored, commit after the later one
      s = $urandom_range(0, 999999); l = $urandom_range(0, 999); v = $urandom_range(0, 20);
      start1(s, l, v);
      busy_low = 0;
      for (int c = 1; c <= 201; c++) begin
         frame = (c == 30 || c == 200);
         tick();
         if (d1_busy !== 1'b1 && c < 201) busy_low++;
         if (c == 31) check_out(1'b1, "sync c31 hold", m1_s, m1_l, m1_v);
         if (c == 200) chk("sync c200 hold", 64'(d1_score), 64'(exp_bcd(m1_s)));
      end
      frame = 1'b0;
      chk("sync busy span", 64'(busy_low), 64'(0));
      m1_s = s; m1_l = l; m1_v = v;
      check_out(1'b1, "sync c201", m1_s, m1_l, m1_v);
      chk("sync busy after", 64'(d1_busy), 64'(0));
      tick();

      // frame pulse in the conversion-finishing cycle does not count
      s = $urandom_range(0, 1048575); l = $urandom_range(0, 99999); v = $urandom_range(0, 9);
      start1(s, l, v);
      for (int c = 1; c <= 76; c++) begin
         frame = (c == 60 || c == 75);
         tick();
         if (c == 62) chk("edge frame ignored", 64'(d1_score), 64'(exp_bcd(m1_s)));
      end
      frame = 1'b0;
      m1_s = s; m1_l = l; m1_v = v;
      check_out(1'b1, "edge frame commit", m1_s, m1_l, m1_v);
      tick();

      // asynchronous reset mid-conversion
      start0($urandom_range(1, 999999), $urandom_range(1, 999), $urandom_range(1, 50));
      repeat (35) tick();
      #3;
      rst_n = 1'b0;
      #1;
      m0_s = 0; m0_l = 0; m0_v = 0; m1_s = 0; m1_l = 0; m1_v = 0;
      check_out(1'b0, "async rst d0", 0, 0, 0);
      check_out(1'b1, "async rst d1", 0, 0, 0);
      chk("async rst busy", 64'(d0_busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) tick();
      check_out(1'b0, "post rst no commit", 0, 0, 0);
      chk("post rst busy", 64'(d0_busy), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
